// File: rtl/inst_encoder_if.sv
// Request/write bus of the instruction encoder: request handshake in, imem write stream and session status out.
interface inst_encoder_if;
  logic        start_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  class_i;
  logic [2:0]  funct_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [12:0] imm_i;
  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic [6:0]  count_o;
  logic        full_o;
  logic        err_o;

  modport slave (
    input  start_i, req_valid_i, class_i, funct_i, rd_i, rs1_i, rs2_i, imm_i,
    output req_ready_o, wr_en_o, wr_addr_o, wr_data_o, count_o, full_o, err_o
  );

  modport master (
    output start_i, req_valid_i, class_i, funct_i, rd_i, rs1_i, rs2_i, imm_i,
    input  req_ready_o, wr_en_o, wr_addr_o, wr_data_o, count_o, full_o, err_o
  );
endinterface

// File: rtl/inst_encoder.sv
// Encodes abstract instruction requests into RV32 words and streams them to imem one cycle after accept.
// Ready depends only on state/count/start; a full session or an idle encoder refuses requests.
module inst_encoder #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic           clk_i,
  input logic           rst_i,
  inst_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_e;

  localparam logic [6:0] DEPTH_C  = 7'(DEPTH);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] CLS_R    = 3'b000;
  localparam logic [2:0] CLS_ADDI = 3'b001;
  localparam logic [2:0] CLS_LW   = 3'b010;
  localparam logic [2:0] CLS_SW   = 3'b011;
  localparam logic [2:0] CLS_BEQ  = 3'b100;

  state_e      state_q, state_d;
  logic [6:0]  count_q, count_d;
  logic        err_q, err_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        req_ready;
  logic        accept;
  logic        legal;
  logic [31:0] enc_word;

  always_comb begin
    legal    = 1'b0;
    enc_word = '0;
    case (bus.class_i)
      CLS_R: begin
        legal = 1'b1;
        case (bus.funct_i)
          3'b000:  enc_word = {7'b0000000, bus.rs2_i, bus.rs1_i, 3'b000, bus.rd_i, OP_R};
          3'b001:  enc_word = {7'b0100000, bus.rs2_i, bus.rs1_i, 3'b000, bus.rd_i, OP_R};
          3'b010:  enc_word = {7'b0000000, bus.rs2_i, bus.rs1_i, 3'b111, bus.rd_i, OP_R};
          3'b011:  enc_word = {7'b0000000, bus.rs2_i, bus.rs1_i, 3'b110, bus.rd_i, OP_R};
          3'b100:  enc_word = {7'b0000001, bus.rs2_i, bus.rs1_i, 3'b000, bus.rd_i, OP_R};
          default: legal = 1'b0;
        endcase
      end
      CLS_ADDI: begin
        legal    = 1'b1;
        enc_word = {bus.imm_i[11:0], bus.rs1_i, 3'b000, bus.rd_i, OP_I};
      end
      CLS_LW: begin
        legal    = 1'b1;
        enc_word = {bus.imm_i[11:0], bus.rs1_i, 3'b010, bus.rd_i, OP_LOAD};
      end
      CLS_SW: begin
        legal    = 1'b1;
        enc_word = {bus.imm_i[11:5], bus.rs2_i, bus.rs1_i, 3'b010, bus.imm_i[4:0], OP_STORE};
      end
      CLS_BEQ: begin
        // Branch offsets are halfword-aligned; an odd offset has no encoding.
        legal    = ~bus.imm_i[0];
        enc_word = {bus.imm_i[12], bus.imm_i[10:5], bus.rs2_i, bus.rs1_i, 3'b000,
                    bus.imm_i[4:1], bus.imm_i[11], OP_BRANCH};
      end
      default: legal = 1'b0;
    endcase
  end

  assign req_ready = (state_q == LOAD) && (count_q < DEPTH_C) && !bus.start_i;
  assign accept    = bus.req_valid_i && req_ready;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (bus.start_i) begin
      state_d = LOAD;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (legal) begin
              wr_en_d   = 1'b1;
              wr_data_d = enc_word;
              wr_addr_d = BASE_ADDR + {23'd0, count_q, 2'b00};
              count_d   = count_q + 7'd1;
              if (count_d == DEPTH_C) begin
                state_d = FULL;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
        IDLE:    state_d = IDLE;
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.wr_en_o     = wr_en_q;
  assign bus.wr_addr_o   = wr_addr_q;
  assign bus.wr_data_o   = wr_data_q;
  assign bus.count_o     = count_q;
  assign bus.full_o      = (state_q == FULL);
  assign bus.err_o       = err_q;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the CPU's opcode-to-control decode. Takes abstract instruction requests (class, operation, register indices, immediate) over a valid/ready handshake.
- Encodes each request into a 32-bit RV32 instruction word and streams it as sequential writes into instruction memory.
- Used as the bench/boot-time program loader for the single-cycle and pipelined cores.
- Covers only the instruction subset the CPU decodes: add, sub, and, or, mul, addi, lw, sw, beq.

Parameters:
- DEPTH, 64: maximum number of instructions written per load session.
- BASE_ADDR, 32'h0000_0000: byte address of the first instruction word.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-low reset.
- start_i  input  1  one-cycle pulse; opens a new load session.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  encoder can accept a request this cycle.
- class_i  input  3  000 R-type, 001 addi, 010 lw, 011 sw, 100 beq; 101-111 illegal.
- funct_i  input  3  R-type op select: 000 add, 001 sub, 010 and, 011 or, 100 mul; 101-111 illegal; ignored for other classes.
- rd_i  input  5  destination register.
- rs1_i  input  5  source register 1.
- rs2_i  input  5  source register 2.
- imm_i  input  13  signed immediate. I/S classes use imm_i[11:0]. beq uses imm_i[12:0] as a byte offset.
- wr_en_o  output  1  instruction memory write strobe.
- wr_addr_o  output  32  byte address of the write.
- wr_data_o  output  32  encoded instruction.
- count_o  output  7  number of instructions written this session (0..DEPTH).
- full_o  output  1  session has reached DEPTH.
- err_o  output  1  sticky: an illegal request was seen this session.

Behaviour:
- Reset (rst_i=0 at an edge): state IDLE, count_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, full_o=0, err_o=0. Reset wins over start_i and over any in-flight accept; a write pending for the next cycle is dropped.
- FSM states: IDLE, LOAD, FULL.
  - IDLE: req_ready_o=0.
  - start_i in any state: next state LOAD; count_o cleared to 0; err_o cleared. If an accept coincides with start_i, start_i wins and the request is not consumed, because req_ready_o is low in that cycle.
  - LOAD: req_ready_o=1 while count_o<DEPTH.
  - FULL: req_ready_o=0, full_o=1. Only start_i or reset leaves FULL.
- req_ready_o is combinational from state and count only, never from req_valid_i. It is forced low in any cycle where start_i=1.
- Accept means req_valid_i && req_ready_o at a rising edge.
- Legal accept at edge N:
  - During cycle N+1: wr_en_o=1, wr_data_o=encoding, wr_addr_o=BASE_ADDR+4*count (count value before the increment).
  - count_o increments at edge N.
  - If the new count equals DEPTH, the state becomes FULL at the same edge, so there are no extra writes.
- Back-to-back accepts produce back-to-back writes at consecutive addresses. wr_en_o is low in every cycle that does not follow an accept.
- Illegal accept: the request is consumed (handshake completes), err_o is set at the same edge, there is no write, and count_o is unchanged.
- Illegal cases:
  - class_i 101-111.
  - R-type with funct_i 101-111.
  - beq with imm_i[0]=1.
- Encodings. All fields are placed at standard RV32 positions: rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20].
  - R-type: opcode 0110011.
    - add: funct7 0000000, funct3 000.
    - sub: funct7 0100000, funct3 000.
    - and: funct7 0000000, funct3 111.
    - or: funct7 0000000, funct3 110.
    - mul: funct7 0000001, funct3 000.
  - addi: opcode 0010011, funct3 000, imm[11:0] in [31:20]; rs2_i ignored.
  - lw: opcode 0000011, funct3 010, imm[11:0] in [31:20]; rs2_i ignored.
  - sw: opcode 0100011, funct3 010, imm[11:5] in [31:25], imm[4:0] in [11:7]; rd_i ignored.
  - beq: opcode 1100011, funct3 000. imm[12] in [31], imm[10:5] in [30:25], imm[4:1] in [11:8], imm[11] in [7]; rd_i ignored.
- wr_data_o and wr_addr_o hold their last values when wr_en_o=0.
- Address arithmetic is 32-bit and wraps modulo 2^32; no overflow flag.

Test Plan:
- Reset, then start_i, then R add rd=3 rs1=1 rs2=2 -> one cycle later wr_en_o=1, wr_addr_o=0x0, wr_data_o=0x002081B3; count_o=1.
- Back-to-back: sub rd=5 rs1=6 rs2=7, lw rd=4 rs1=1 imm=8, sw rs1=1 rs2=2 imm=12 -> consecutive writes:
  - 0x407302B3 at 0x0.
  - 0x0080A203 at 0x4.
  - 0x0020A623 at 0x8.
- beq rs1=1 rs2=2 imm=-8 (13'h1FF8) -> 0xFE208CE3. beq with imm=5 -> no write, err_o=1, count_o unchanged.
- DEPTH=4, req_valid_i held high for 6 cycles -> exactly 4 writes at 0x0, 0x4, 0x8, 0xC; full_o=1 and req_ready_o=0 from the edge of the 4th accept.
- class_i=110 and R-type funct_i=111 -> both consumed, no wr_en_o, err_o=1 sticky; the next start_i clears err_o and count_o.
- rst_i low in the cycle after an accept -> wr_en_o=0 at the next edge and all outputs at reset values; start_i asserted together with req_valid_i -> request not accepted, count_o=0.
